// File: rtl/stepper_dekoder_faza.sv
// Stepper coil-phase decoder.
// Samples the observed coil pattern once and debounces it.
// Tracks the phase sequence and maintains a signed step position.
// Flags skipped or illegal phases as faults.
// Optional stall watchdog: define STEPPER_DEKODER_TIMEOUT_EN.
module stepper_dekoder_faza #(
    parameter int          STABLE_CYC  = 4,
    parameter int          LIMIT       = 850,
    parameter logic [31:0] TIMEOUT_CYC = 32'd300_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  faze,
    input  logic        clr_pos,
    output logic [15:0] pozicija,
    output logic        smjer,
    output logic        korak_puls,
    output logic        motor_miruje,
    output logic        na_granici,
    output logic        greska,
    output logic [7:0]  broj_gresaka,
    output logic        zastoj
);

    localparam logic [7:0]         STAB_LAST = 8'(STABLE_CYC - 1);
    localparam logic signed [15:0] LIMIT_S   = 16'(LIMIT);

    typedef enum logic {IDLE = 1'b0, TRACK = 1'b1} state_t;

    // Returns {valid, phase index}; 0000 and illegal codes return valid = 0.
    function automatic logic [2:0] dekodiraj(input logic [3:0] f);
        case (f)
            4'b1100: dekodiraj = 3'b100;
            4'b0110: dekodiraj = 3'b101;
            4'b0011: dekodiraj = 3'b110;
            4'b1001: dekodiraj = 3'b111;
            default: dekodiraj = 3'b000;
        endcase
    endfunction

    state_t              state_q, state_d;
    logic [3:0]          faze_r;
    logic [3:0]          acc_pat;
    logic [7:0]          stab_cnt;
    logic [1:0]          ref_q;
    logic [2:0]          dec;
    logic [1:0]          delta;
    logic                accept;
    logic                step_up, step_dn, fault, ref_ld;
    logic signed [15:0]  poz_q;

    assign dec    = dekodiraj(faze_r);
    assign delta  = dec[1:0] - ref_q;
    // A pattern is accepted once, after it sat in faze_r for STABLE_CYC clocks,
    // and only if it differs from the last accepted one (glitches back to the
    // same pattern therefore do nothing).
    assign accept = (stab_cnt == STAB_LAST) && (faze_r != acc_pat);

    // Input register and stability counter; counter holds at its terminal value.
    always_ff @(posedge clk) begin
        if (rst) begin
            faze_r   <= 4'b0000;
            stab_cnt <= 8'd0;
        end else begin
            faze_r <= faze;
            if (faze != faze_r)
                stab_cnt <= 8'd0;
            else if (stab_cnt != STAB_LAST)
                stab_cnt <= stab_cnt + 8'd1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and step/fault events for an accepted pattern.
    always_comb begin
        state_d = state_q;
        step_up = 1'b0;
        step_dn = 1'b0;
        fault   = 1'b0;
        ref_ld  = 1'b0;
        if (accept) begin
            if (faze_r == 4'b0000) begin
                state_d = IDLE;
            end else if (!dec[2]) begin
                fault   = 1'b1;
                state_d = IDLE;
            end else if (state_q == IDLE) begin
                ref_ld  = 1'b1;
                state_d = TRACK;
            end else begin
                case (delta)
                    2'd1: begin step_up = 1'b1; ref_ld = 1'b1; end
                    2'd3: begin step_dn = 1'b1; ref_ld = 1'b1; end
                    2'd2: begin fault   = 1'b1; ref_ld = 1'b1; end
                    default: ;
                endcase
            end
        end
    end

    // Position, direction, pulse, reference phase and fault bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            poz_q        <= 16'sd0;
            smjer        <= 1'b0;
            korak_puls   <= 1'b0;
            greska       <= 1'b0;
            broj_gresaka <= 8'd0;
            ref_q        <= 2'd0;
            acc_pat      <= 4'b0000;
        end else begin
            korak_puls <= step_up | step_dn;
            if (step_up) smjer <= 1'b1;
            if (step_dn) smjer <= 1'b0;
            // clr_pos overrides any step taken in the same clock.
            if (clr_pos)      poz_q <= 16'sd0;
            else if (step_up) poz_q <= poz_q + 16'sd1;
            else if (step_dn) poz_q <= poz_q - 16'sd1;
            if (ref_ld) ref_q   <= dec[1:0];
            if (accept) acc_pat <= faze_r;
            if (fault) begin
                greska <= 1'b1;
                if (broj_gresaka != 8'hFF) broj_gresaka <= broj_gresaka + 8'd1;
            end
        end
    end

`ifdef STEPPER_DEKODER_TIMEOUT_EN
    logic [31:0] tmo_cnt;
    logic        zastoj_q;

    // Stall watchdog: runs in TRACK, restarts on any step or state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt  <= 32'd0;
            zastoj_q <= 1'b0;
        end else if (step_up || step_dn || (state_d != state_q)) begin
            tmo_cnt  <= 32'd0;
            zastoj_q <= 1'b0;
        end else if (state_q == TRACK) begin
            if (tmo_cnt != TIMEOUT_CYC) tmo_cnt <= tmo_cnt + 32'd1;
            if (tmo_cnt == TIMEOUT_CYC - 32'd1) zastoj_q <= 1'b1;
        end else begin
            tmo_cnt <= 32'd0;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
`endif

    // Output decode.
    always_comb begin
        pozicija     = poz_q;
        motor_miruje = (acc_pat == 4'b0000);
        na_granici   = (poz_q == LIMIT_S);
`ifdef STEPPER_DEKODER_TIMEOUT_EN
        zastoj       = zastoj_q;
`else
        zastoj       = 1'b0;
`endif
    end

endmodule

// File: tb/tb_stepper_dekoder_faza.sv
// Directed bench for stepper_dekoder_faza (STABLE_CYC=4, LIMIT=3, TIMEOUT_CYC=100).
module tb_stepper_dekoder_faza;

    localparam int SC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  faze;
    logic        clr_pos;
    logic [15:0] pozicija;
    logic        smjer, korak_puls, motor_miruje, na_granici, greska, zastoj;
    logic [7:0]  broj_gresaka;

    int errors = 0;
    int checks = 0;

    stepper_dekoder_faza #(.STABLE_CYC(SC), .LIMIT(3), .TIMEOUT_CYC(32'd100)) dut (
        .clk(clk), .rst(rst), .faze(faze), .clr_pos(clr_pos),
        .pozicija(pozicija), .smjer(smjer), .korak_puls(korak_puls),
        .motor_miruje(motor_miruje), .na_granici(na_granici), .greska(greska),
        .broj_gresaka(broj_gresaka), .zastoj(zastoj)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]         f;
        logic               clr;
        logic signed [15:0] pos;
        logic               smj;
        int                 pulses;
        logic               gr;
        logic [7:0]         br;
        logic               mir;
        logic               ng;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Present a pattern for 10 clocks, optionally pulsing clr_pos on the acceptance edge.
    task automatic apply(input logic [3:0] f, input logic c, output int np);
        @(negedge clk);
        faze = f;
        np = 0;
        for (int i = 1; i <= 10; i++) begin
            if (c && i == SC + 1) clr_pos = 1'b1;
            @(posedge clk);
            #1;
            clr_pos = 1'b0;
            if (korak_puls) np++;
        end
    endtask

    initial begin
        int np;
        vecs[0]  = '{4'b1100, 1'b0,  16'sd0, 1'b0, 0, 1'b0, 8'd0, 1'b0, 1'b0};
        vecs[1]  = '{4'b0110, 1'b0,  16'sd1, 1'b1, 1, 1'b0, 8'd0, 1'b0, 1'b0};
        vecs[2]  = '{4'b0011, 1'b0,  16'sd2, 1'b1, 1, 1'b0, 8'd0, 1'b0, 1'b0};
        vecs[3]  = '{4'b1001, 1'b0,  16'sd3, 1'b1, 1, 1'b0, 8'd0, 1'b0, 1'b1};
        vecs[4]  = '{4'b0011, 1'b0,  16'sd2, 1'b0, 1, 1'b0, 8'd0, 1'b0, 1'b0};
        vecs[5]  = '{4'b0110, 1'b0,  16'sd1, 1'b0, 1, 1'b0, 8'd0, 1'b0, 1'b0};
        vecs[6]  = '{4'b1100, 1'b0,  16'sd0, 1'b0, 1, 1'b0, 8'd0, 1'b0, 1'b0};
        vecs[7]  = '{4'b1001, 1'b0, -16'sd1, 1'b0, 1, 1'b0, 8'd0, 1'b0, 1'b0};
        vecs[8]  = '{4'b0011, 1'b0, -16'sd2, 1'b0, 1, 1'b0, 8'd0, 1'b0, 1'b0};
        vecs[9]  = '{4'b1001, 1'b0, -16'sd1, 1'b1, 1, 1'b0, 8'd0, 1'b0, 1'b0};
        vecs[10] = '{4'b1100, 1'b0,  16'sd0, 1'b1, 1, 1'b0, 8'd0, 1'b0, 1'b0};
        vecs[11] = '{4'b0011, 1'b0,  16'sd0, 1'b1, 0, 1'b1, 8'd1, 1'b0, 1'b0};
        vecs[12] = '{4'b1010, 1'b0,  16'sd0, 1'b1, 0, 1'b1, 8'd2, 1'b0, 1'b0};
        vecs[13] = '{4'b0110, 1'b0,  16'sd0, 1'b1, 0, 1'b1, 8'd2, 1'b0, 1'b0};
        vecs[14] = '{4'b0011, 1'b0,  16'sd1, 1'b1, 1, 1'b1, 8'd2, 1'b0, 1'b0};
        vecs[15] = '{4'b0000, 1'b0,  16'sd1, 1'b1, 0, 1'b1, 8'd2, 1'b1, 1'b0};
        vecs[16] = '{4'b0011, 1'b0,  16'sd1, 1'b1, 0, 1'b1, 8'd2, 1'b0, 1'b0};
        vecs[17] = '{4'b1001, 1'b1,  16'sd0, 1'b1, 1, 1'b1, 8'd2, 1'b0, 1'b0};
        vecs[18] = '{4'b0011, 1'b0, -16'sd1, 1'b0, 1, 1'b1, 8'd2, 1'b0, 1'b0};

        rst = 1'b1; faze = 4'b0000; clr_pos = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset pozicija", int'($signed(pozicija)), 0);
        chk("reset smjer", smjer, 0);
        chk("reset korak_puls", korak_puls, 0);
        chk("reset greska", greska, 0);
        chk("reset broj_gresaka", broj_gresaka, 0);
        chk("reset zastoj", zastoj, 0);
        chk("reset motor_miruje", motor_miruje, 1);
        chk("reset na_granici", na_granici, 0);

        for (int v = 0; v < 19; v++) begin
            apply(vecs[v].f, vecs[v].clr, np);
            chk($sformatf("v%0d pozicija", v), int'($signed(pozicija)), int'(vecs[v].pos));
            chk($sformatf("v%0d smjer", v), smjer, vecs[v].smj);
            chk($sformatf("v%0d pulses", v), np, vecs[v].pulses);
            chk($sformatf("v%0d greska", v), greska, vecs[v].gr);
            chk($sformatf("v%0d broj_gresaka", v), broj_gresaka, vecs[v].br);
            chk($sformatf("v%0d motor_miruje", v), motor_miruje, vecs[v].mir);
            chk($sformatf("v%0d na_granici", v), na_granici, vecs[v].ng);
        end

        // Latency: ref phase 2, pozicija -1; 0110 is a down step landing on edge SC+1.
        @(negedge clk);
        faze = 4'b0110;
        repeat (SC) @(posedge clk);
        #1;
        chk("latency pulse early", korak_puls, 0);
        chk("latency pos early", int'($signed(pozicija)), -1);
        @(posedge clk); #1;
        chk("latency pulse on time", korak_puls, 1);
        chk("latency pos on time", int'($signed(pozicija)), -2);
        @(posedge clk); #1;
        chk("pulse one clock", korak_puls, 0);
        repeat (5) @(posedge clk);

        // Glitch shorter than STABLE_CYC is ignored.
        @(negedge clk);
        faze = 4'b0011;
        repeat (2) @(negedge clk);
        np = 0;
        faze = 4'b0110;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (korak_puls) np++;
        end
        chk("glitch pulses", np, 0);
        chk("glitch pozicija", int'($signed(pozicija)), -2);

        // Hold in TRACK beyond the stall window.
        repeat (110) @(posedge clk);
        #1;
`ifdef STEPPER_DEKODER_TIMEOUT_EN
        chk("zastoj after hold", zastoj, 1);
`else
        chk("zastoj after hold", zastoj, 0);
`endif
        apply(4'b0011, 1'b0, np);
        chk("step after hold pulses", np, 1);
        chk("step after hold pozicija", int'($signed(pozicija)), -1);
        chk("zastoj after step", zastoj, 0);

        // Reset in the middle of a pending acceptance.
        @(negedge clk);
        faze = 4'b1001;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst pozicija", int'($signed(pozicija)), 0);
        chk("midrst smjer", smjer, 0);
        chk("midrst korak_puls", korak_puls, 0);
        chk("midrst greska", greska, 0);
        chk("midrst broj_gresaka", broj_gresaka, 0);
        chk("midrst motor_miruje", motor_miruje, 1);
        chk("midrst na_granici", na_granici, 0);
        chk("midrst zastoj", zastoj, 0);
        np = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (korak_puls) np++;
        end
        chk("after rst pulses", np, 0);
        chk("after rst pozicija", int'($signed(pozicija)), 0);
        chk("after rst motor_miruje", motor_miruje, 0);

        // 256 illegal codes: fault count saturates at 255.
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            faze = (k % 2 == 0) ? 4'b1010 : 4'b0101;
            repeat (5) @(negedge clk);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("broj_gresaka saturated", broj_gresaka, 255);
        chk("greska sticky", greska, 1);
        chk("pozicija after faults", int'($signed(pozicija)), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
